// File: rtl/frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer_if
// Brief    : Pixel stream bundle; producer side (src_*) and FIFO side (dst_*).
// Revision : 1.0 - initial release
// ============================================================================
interface frame_sequencer_if;
    logic [7:0] src_pixel;
    logic       src_valid;
    logic       src_ready;
    logic [7:0] dst_pixel;
    logic       dst_valid;
    logic       dst_ready;
    logic       dst_sof;
    logic       dst_eol;
    logic       dst_eof;

    // Sequencer side: consumes the producer stream, drives the framed stream.
    modport master (
        input  src_pixel,
        input  src_valid,
        output src_ready,
        output dst_pixel,
        output dst_valid,
        input  dst_ready,
        output dst_sof,
        output dst_eol,
        output dst_eof
    );

    // Environment side: producer plus downstream FIFO.
    modport slave (
        output src_pixel,
        output src_valid,
        input  src_ready,
        input  dst_pixel,
        input  dst_valid,
        output dst_ready,
        input  dst_sof,
        input  dst_eol,
        input  dst_eof
    );
endinterface
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Brief    : Gates a pixel stream into tagged frames with inter-frame gaps,
//            programmed or continuous frame count, and graceful stop.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int IMAGE_WIDTH  = 32,
    parameter int IMAGE_HEIGHT = 32,
    parameter int GAP_CYCLES   = 16,
    parameter int FRAME_CNT_W  = 8
) (
    input  wire logic                   sensor_clk,
    input  wire logic                   rst,
    input  wire logic                   start,
    input  wire logic                   stop,
    input  wire logic [FRAME_CNT_W-1:0] num_frames,
    frame_sequencer_if.master           bus,
    output logic                        busy,
    output logic                        done,
    output logic [FRAME_CNT_W-1:0]      frames_done
);

    localparam int c_COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int c_ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int c_GAP_W = (GAP_CYCLES   > 1) ? $clog2(GAP_CYCLES)   : 1;

    localparam logic [c_COL_W-1:0]     c_COL_LAST = c_COL_W'(IMAGE_WIDTH - 1);
    localparam logic [c_ROW_W-1:0]     c_ROW_LAST = c_ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [c_GAP_W-1:0]     c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_COL_W-1:0]     c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0]     c_ROW_ONE  = c_ROW_W'(1);
    localparam logic [c_GAP_W-1:0]     c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [FRAME_CNT_W-1:0] c_FRM_ONE  = FRAME_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [c_COL_W-1:0]      r_col;
    logic [c_ROW_W-1:0]      r_row;
    logic [c_GAP_W-1:0]      r_gap;
    logic [FRAME_CNT_W-1:0]  r_frames_done;
    logic [FRAME_CNT_W-1:0]  r_num_frames;
    logic                    r_stop_pending;
    logic                    r_done;

    logic [7:0]              r_dst_pixel;
    logic                    r_dst_valid;
    logic                    r_dst_sof;
    logic                    r_dst_eol;
    logic                    r_dst_eof;

    logic                    w_src_ready;
    logic                    w_xfer;
    logic                    w_sof;
    logic                    w_eol;
    logic                    w_eof;
    logic [FRAME_CNT_W-1:0]  w_frames_inc;
    logic                    w_last_frame;
    logic                    w_gap_last;

    assign w_src_ready  = (r_state == S_STREAM) && (!r_dst_valid || bus.dst_ready);
    assign w_xfer       = w_src_ready && bus.src_valid;

    assign w_sof        = (r_col == '0) && (r_row == '0);
    assign w_eol        = (r_col == c_COL_LAST);
    assign w_eof        = w_eol && (r_row == c_ROW_LAST);

    // num_frames == 0 means continuous, so the limit never matches.
    assign w_frames_inc = r_frames_done + c_FRM_ONE;
    assign w_last_frame = (r_num_frames != '0) && (w_frames_inc == r_num_frames);
    assign w_gap_last   = (r_gap == c_GAP_LAST);

    always_ff @(posedge sensor_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                // A stop arriving with the eof transfer still ends the run.
                if (w_xfer && w_eof) begin
                    w_state_nxt = (r_stop_pending || stop || w_last_frame) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (stop || r_stop_pending) begin
                    w_state_nxt = S_DONE;
                end else if (w_gap_last) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_DONE: begin
                if (!r_dst_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sensor_clk) begin
        if (rst) begin
            r_col          <= '0;
            r_row          <= '0;
            r_gap          <= '0;
            r_frames_done  <= '0;
            r_num_frames   <= '0;
            r_stop_pending <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE) && !r_dst_valid;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frames_done  <= '0;
                        r_stop_pending <= 1'b0;
                        r_num_frames   <= num_frames;
                        r_col          <= '0;
                        r_row          <= '0;
                    end
                end
                S_STREAM: begin
                    if (stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (w_eol) begin
                            r_col <= '0;
                            r_row <= w_eof ? '0 : (r_row + c_ROW_ONE);
                        end else begin
                            r_col <= r_col + c_COL_ONE;
                        end
                        if (w_eof) begin
                            r_frames_done <= w_frames_inc;
                            r_gap         <= '0;
                        end
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + c_GAP_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // Output register: loads on transfer, clears once consumed with no refill.
    always_ff @(posedge sensor_clk) begin
        if (rst) begin
            r_dst_pixel <= '0;
            r_dst_valid <= 1'b0;
            r_dst_sof   <= 1'b0;
            r_dst_eol   <= 1'b0;
            r_dst_eof   <= 1'b0;
        end else if (w_xfer) begin
            r_dst_pixel <= bus.src_pixel;
            r_dst_valid <= 1'b1;
            r_dst_sof   <= w_sof;
            r_dst_eol   <= w_eol;
            r_dst_eof   <= w_eof;
        end else if (bus.dst_ready) begin
            r_dst_valid <= 1'b0;
        end
    end

    assign bus.src_ready = w_src_ready;
    assign bus.dst_pixel = r_dst_pixel;
    assign bus.dst_valid = r_dst_valid;
    assign bus.dst_sof   = r_dst_sof;
    assign bus.dst_eol   = r_dst_eol;
    assign bus.dst_eof   = r_dst_eof;

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign frames_done = r_frames_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sequencer
// Brief    : Randomized scoreboard bench for frame_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    localparam int W     = 32;
    localparam int H     = 32;
    localparam int GAP   = 16;
    localparam int FW    = 8;
    localparam int FRAME = W * H;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [FW-1:0] num_frames;
    logic          busy;
    logic          done;
    logic [FW-1:0] frames_done;

    frame_sequencer_if bus ();

    frame_sequencer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .GAP_CYCLES  (GAP),
        .FRAME_CNT_W (FW)
    ) dut (
        .sensor_clk (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .num_frames (num_frames),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    exp_t          exp_q[$];
    int            pix_total = 0;
    int            n_out, n_sof, n_eol, n_eof, n_done;
    int            gaps[$];
    logic [FW-1:0] fd_seen[$];
    int            src_p = 100;
    int            dst_p = 100;
    bit            prev_stall = 0;
    exp_t          prev_out;
    bit            in_gap = 0;
    int            gap_len = 0;
    bit            fd_pending = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start         = 1'b0;
        stop          = 1'b0;
        bus.src_valid = ($urandom_range(99) < src_p);
        bus.src_pixel = 8'($urandom);
        bus.dst_ready = ($urandom_range(99) < dst_p);
    endtask

    task automatic clear_stats();
        n_out = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_done = 0;
        gaps.delete();
        fd_seen.delete();
    endtask

    task automatic pulse_start(input logic [FW-1:0] nf, input logic with_stop);
        step();
        num_frames = nf;
        start      = 1'b1;
        stop       = with_stop;
        step();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!(n_done > 0 && !busy) && n < budget) begin
            step();
            n++;
        end
        chk(name, (n < budget) ? 1 : 0, 1);
        repeat (4) step();
    endtask

    task automatic wait_pix(input int target, input int budget, input string name);
        int n = 0;
        while (pix_total < target && n < budget) begin
            step();
            n++;
        end
        chk(name, (n < budget) ? 1 : 0, 1);
    endtask

    // Monitor: reference tags come from the pixel's index within its frame.
    initial forever begin
        exp_t got;
        exp_t e;
        int   idx;
        @(negedge clk);
        if (rst) begin
            prev_stall = 0;
            in_gap     = 0;
            fd_pending = 0;
        end else begin
            got = {bus.dst_pixel, bus.dst_sof, bus.dst_eol, bus.dst_eof};
            if (fd_pending) begin
                fd_seen.push_back(frames_done);
                fd_pending = 0;
            end
            if (done) n_done++;
            if (prev_stall) chk("stall_hold", {bus.dst_valid, got}, {1'b1, prev_out});
            prev_stall = bus.dst_valid && !bus.dst_ready;
            prev_out   = got;
            if (bus.dst_valid && bus.dst_ready) begin
                chk("out_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_pixel_tags", got, e);
                end
                n_out++;
                if (got.sof) n_sof++;
                if (got.eol) n_eol++;
                if (got.eof) n_eof++;
            end
            if (in_gap) begin
                if (bus.src_ready) begin
                    gaps.push_back(gap_len);
                    in_gap = 0;
                end else if (!busy) begin
                    in_gap = 0;
                end else begin
                    gap_len++;
                end
            end
            if (bus.src_valid && bus.src_ready) begin
                idx   = pix_total % FRAME;
                e.pix = bus.src_pixel;
                e.sof = (idx == 0);
                e.eol = ((idx % W) == W - 1);
                e.eof = (idx == FRAME - 1);
                exp_q.push_back(e);
                pix_total++;
                if (e.eof) begin
                    fd_pending = 1;
                    in_gap     = 1;
                    gap_len    = 0;
                end
            end
        end
    end

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; stop = 1'b0; num_frames = '0;
        bus.src_valid = 1'b0; bus.src_pixel = '0; bus.dst_ready = 1'b0;
        repeat (3) step();
        chk("rst_dst_valid", bus.dst_valid, 0);
        chk("rst_dst_bits", {bus.dst_pixel, bus.dst_sof, bus.dst_eol, bus.dst_eof}, 0);
        chk("rst_status", {busy, done, bus.src_ready}, 0);
        chk("rst_frames_done", frames_done, 0);
        rst = 1'b0;

        // Single frame, full throughput.
        clear_stats();
        src_p = 100; dst_p = 100;
        step();
        num_frames = 1; start = 1'b1;
        chk("t1_ready_at_start", bus.src_ready, 0);
        step();
        chk("t1_ready_after_start", bus.src_ready, 1);
        chk("t1_busy", busy, 1);
        wait_done(3000, "t1_done_timeout");
        chk("t1_out_count", n_out, FRAME);
        chk("t1_sof_count", n_sof, 1);
        chk("t1_eol_count", n_eol, H);
        chk("t1_eof_count", n_eof, 1);
        chk("t1_done_pulses", n_done, 1);
        chk("t1_frames_done", frames_done, 1);
        chk("t1_busy_end", busy, 0);

        // Three frames with idle gaps.
        clear_stats();
        src_p = 80; dst_p = 100;
        pulse_start(3, 1'b0);
        wait_done(6000, "t2_done_timeout");
        chk("t2_out_count", n_out, 3 * FRAME);
        chk("t2_gap_count", gaps.size(), 2);
        chk("t2_gap0", (gaps.size() > 0) ? gaps[0] : -1, GAP);
        chk("t2_gap1", (gaps.size() > 1) ? gaps[1] : -1, GAP);
        chk("t2_fd_count", fd_seen.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("t2_fd_value", (fd_seen.size() > i) ? fd_seen[i] : 8'hff, i + 1);
        chk("t2_done_pulses", n_done, 1);
        chk("t2_frames_done", frames_done, 3);

        // Continuous run stopped mid frame 2.
        clear_stats();
        pulse_start(0, 1'b0);
        base = pix_total;
        wait_pix(base + FRAME + 500, 4000, "t3_pix_timeout");
        stop = 1'b1;
        step();
        wait_done(4000, "t3_done_timeout");
        chk("t3_out_count", n_out, 2 * FRAME);
        chk("t3_eof_count", n_eof, 2);
        chk("t3_gap_count", gaps.size(), 1);
        chk("t3_done_pulses", n_done, 1);
        chk("t3_frames_done", frames_done, 2);

        // Random backpressure.
        clear_stats();
        src_p = 70; dst_p = 50;
        pulse_start(2, 1'b0);
        wait_done(14000, "t4_done_timeout");
        chk("t4_out_count", n_out, 2 * FRAME);
        chk("t4_sof_count", n_sof, 2);
        chk("t4_eol_count", n_eol, 2 * H);
        chk("t4_eof_count", n_eof, 2);
        chk("t4_frames_done", frames_done, 2);
        chk("t4_done_pulses", n_done, 1);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Reset mid-frame, then a fresh run.
        clear_stats();
        src_p = 100; dst_p = 100;
        pulse_start(1, 1'b0);
        base = pix_total;
        wait_pix(base + 300, 1000, "t5_pix_timeout");
        rst = 1'b1;
        step();
        chk("t5_rst_dst_valid", bus.dst_valid, 0);
        chk("t5_rst_dst_bits", {bus.dst_pixel, bus.dst_sof, bus.dst_eol, bus.dst_eof}, 0);
        chk("t5_rst_status", {busy, done, bus.src_ready}, 0);
        chk("t5_rst_frames_done", frames_done, 0);
        exp_q.delete();
        pix_total = 0;
        step();
        rst = 1'b0;
        clear_stats();
        pulse_start(1, 1'b0);
        wait_done(3000, "t5_done_timeout");
        chk("t5_out_count", n_out, FRAME);
        chk("t5_sof_count", n_sof, 1);
        chk("t5_frames_done", frames_done, 1);

        // Stop in IDLE, start+stop together, start while busy.
        clear_stats();
        step();
        stop = 1'b1;
        step();
        step();
        chk("t6_idle_stop_busy", busy, 0);
        chk("t6_idle_stop_fd", frames_done, 1);
        pulse_start(2, 1'b1);
        chk("t6_busy", busy, 1);
        base = pix_total;
        wait_pix(base + 100, 1000, "t6_pix_timeout");
        num_frames = 1; start = 1'b1;
        step();
        wait_done(4000, "t6_done_timeout");
        chk("t6_out_count", n_out, 2 * FRAME);
        chk("t6_frames_done", frames_done, 2);
        chk("t6_done_pulses", n_done, 1);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Sequences the sensor pixel stream from the data producer into framed bursts for the downstream FIFO.
- Gates the producer's ready and counts accepted pixels into columns, rows and frames.
- Tags each pixel with start-of-frame, end-of-line and end-of-frame markers.
- Runs a programmed number of frames, or runs continuously, with a fixed idle gap between frames; supports a graceful stop.

Parameters:
IMAGE_WIDTH, 32, pixels per line
IMAGE_HEIGHT, 32, lines per frame (IMAGE_WIDTH*IMAGE_HEIGHT equals the producer IMAGE_SIZE)
GAP_CYCLES, 16, idle cycles between frames (minimum 1)
FRAME_CNT_W, 8, width of the frame count and frame limit

Ports:
sensor_clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run
stop  in  1  one-cycle pulse; finish the current frame, then end the run
num_frames  in  FRAME_CNT_W  frames per run, sampled on start; 0 = continuous
src_pixel  in  8  pixel from producer
src_valid  in  1  producer pixel valid
src_ready  out  1  to producer ready
dst_pixel  out  8  registered pixel to FIFO
dst_valid  out  1  output valid
dst_ready  in  1  FIFO not full
dst_sof  out  1  dst_pixel is first pixel of frame
dst_eol  out  1  dst_pixel is last pixel of line
dst_eof  out  1  dst_pixel is last pixel of frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at run end
frames_done  out  FRAME_CNT_W  completed frames this run

Behaviour:
Reset:
- All outputs are 0.
- State is IDLE; column, row, gap and frame counters are 0; stop_pending is 0.
- Reset is honoured in any state, including mid-frame. Any held output pixel is discarded.

Handshake:
- src_ready = (state==STREAM) && (!dst_valid || dst_ready).
- A transfer occurs in a cycle where src_valid && src_ready are both high.
- On a transfer, the next edge loads dst_pixel and the tags, and sets dst_valid=1. Latency is 1 cycle.
- If dst_valid && dst_ready and there is no transfer, dst_valid clears at the next edge.
- dst_pixel and the tags are held stable while dst_valid && !dst_ready.
- The block never drops or duplicates a transferred pixel.

Tags and counters:
- Tags are computed from the counters at transfer time:
  - sof = (col==0 && row==0)
  - eol = (col==IMAGE_WIDTH-1)
  - eof = eol && (row==IMAGE_HEIGHT-1)
- col increments per transfer and wraps to 0 after IMAGE_WIDTH-1; row increments on that wrap.
- Both counters return to 0 after the eof transfer.

States:
- IDLE:
  - start -> STREAM, clears frames_done and stop_pending, latches num_frames.
  - stop is ignored.
- STREAM:
  - On the eof transfer, frames_done increments at the same edge.
  - If stop_pending, or num_frames!=0 and frames_done+1==num_frames -> DONE.
  - Otherwise -> GAP, gap counter loads 0.
- GAP:
  - src_ready=0. Counts GAP_CYCLES cycles, then -> STREAM.
  - stop, or a stop_pending already set -> DONE on the next edge.
- DONE:
  - Waits until dst_valid==0 (final pixel drained).
  - Then asserts done for exactly 1 cycle and returns to IDLE.
  - frames_done holds its value until the next start.

Stop handling:
- stop in STREAM sets stop_pending. The current frame completes to eof; no frame is truncated.
- stop and eof in the same cycle are treated as pending, so the run ends after that frame.
- start while busy is ignored.
- start and stop in the same cycle in IDLE: start wins; the stop is ignored.

Arithmetic:
- frames_done wraps modulo 2^FRAME_CNT_W in continuous mode. The wrap has no other effect.

Test Plan:
- Reset, then start with num_frames=1, dst_ready=1, producer streaming -> src_ready rises the cycle after start.
  - 1024 pixels emitted; dst_sof on pixel 0; dst_eol on pixels 31, 63, …, 1023; dst_eof only on pixel 1023.
  - frames_done=1; done pulses once; busy falls.
- num_frames=3 -> three frames, each separated by exactly 16 cycles with src_ready=0; frames_done reads 1, 2, 3; a single done pulse.
- num_frames=0 with stop asserted at pixel 500 of frame 2 -> frame 2 completes through pixel 1023, with no GAP afterwards; done pulses; frames_done=2.
- dst_ready toggled randomly 50% -> dst_pixel sequence equals the accepted src_pixel sequence exactly; outputs stable while stalled; tags still land on correct indices.
- rst asserted mid-frame at pixel 300 -> next cycle all outputs 0, IDLE; a new start gives dst_sof on the first pixel.
- start pulsed while busy, and stop pulsed in IDLE -> no effect on state, counters or frames_done.
